// File: rtl/pattern_gen_pkg.sv
// pattern_gen_pkg
// Shared type definitions for the pattern generator:
//   mode_e  - pattern selection carried on the mode input
//   state_e - burst FSM states
package pattern_gen_pkg;

    typedef enum logic [1:0] {
        MODE_CONST  = 2'd0,
        MODE_TOGGLE = 2'd1,
        MODE_COUNT  = 2'd2,
        MODE_WALK   = 2'd3
    } mode_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_e;

endpackage

// File: rtl/pattern_gen_if.sv
// pattern_gen_if
// Control and valid/ready stream bundle of the pattern generator.
//   start, mode, burst_len, seed : burst request from the harness
//   data, valid / ready          : output stream to the sink
//   busy, done                   : burst status
// modport master : the generator
// modport slave  : harness / sink side
interface pattern_gen_if #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned LEN_W = 8
);
    logic             start;
    logic [1:0]       mode;
    logic [LEN_W-1:0] burst_len;
    logic [WIDTH-1:0] seed;
    logic [WIDTH-1:0] data;
    logic             valid;
    logic             ready;
    logic             busy;
    logic             done;

    modport master (
        input  start, mode, burst_len, seed, ready,
        output data, valid, busy, done
    );

    modport slave (
        output start, mode, burst_len, seed, ready,
        input  data, valid, busy, done
    );
endinterface

// File: rtl/pattern_step.sv
// pattern_step
// Combinational next-word function of the generator.
//   i_mode : pattern mode
//   i_cur  : current word
//   o_nxt  : word following i_cur in the selected pattern
module pattern_step
    import pattern_gen_pkg::*;
#(
    parameter int unsigned WIDTH = 8
) (
    input  mode_e            i_mode,
    input  logic [WIDTH-1:0] i_cur,
    output logic [WIDTH-1:0] o_nxt
);

    always_comb begin
        o_nxt = i_cur;
        case (i_mode)
            MODE_CONST:  o_nxt = i_cur;
            MODE_TOGGLE: o_nxt = ~i_cur;
            MODE_COUNT:  o_nxt = i_cur + WIDTH'(1);
            // rotate left; MSB re-enters at bit 0
            MODE_WALK:   o_nxt = {i_cur[WIDTH-2:0], i_cur[WIDTH-1]};
            default:     o_nxt = i_cur;
        endcase
    end

endmodule

// File: rtl/pattern_gen.sv
// pattern_gen
// Registered data-pattern source. A start request in IDLE latches mode,
// seed and length, then streams burst_len words over valid/ready and
// pulses done for one cycle. A zero-length request goes straight to DONE.
//   clk   : system clock, rising edge
//   rst_n : asynchronous active-low reset
//   bus   : pattern_gen_if master (request, stream and status signals)
module pattern_gen
    import pattern_gen_pkg::*;
#(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned LEN_W = 8
) (
    input logic            clk,
    input logic            rst_n,
    pattern_gen_if.master  bus
);

    state_e           r_state, w_state_nxt;
    mode_e            r_mode,  w_mode_nxt;
    logic [WIDTH-1:0] r_data,  w_data_nxt, w_step;
    logic             r_valid, w_valid_nxt;
    logic [LEN_W-1:0] r_rem,   w_rem_nxt;

    pattern_step #(.WIDTH(WIDTH)) u_step (
        .i_mode (r_mode),
        .i_cur  (r_data),
        .o_nxt  (w_step)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
            r_mode  <= MODE_CONST;
            r_data  <= '0;
            r_valid <= 1'b0;
            r_rem   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_mode  <= w_mode_nxt;
            r_data  <= w_data_nxt;
            r_valid <= w_valid_nxt;
            r_rem   <= w_rem_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_mode_nxt  = r_mode;
        w_data_nxt  = r_data;
        w_valid_nxt = r_valid;
        w_rem_nxt   = r_rem;
        case (r_state)
            ST_IDLE: begin
                if (bus.start) begin
                    if (bus.burst_len != '0) begin
                        w_mode_nxt  = mode_e'(bus.mode);
                        w_data_nxt  = bus.seed;
                        w_valid_nxt = 1'b1;
                        w_rem_nxt   = bus.burst_len;
                        w_state_nxt = ST_RUN;
                    end else begin
                        w_state_nxt = ST_DONE;
                    end
                end
            end
            ST_RUN: begin
                // a stall (valid && !ready) falls through with everything held
                if (r_valid && bus.ready) begin
                    if (r_rem == LEN_W'(1)) begin
                        w_valid_nxt = 1'b0;
                        w_rem_nxt   = '0;
                        w_state_nxt = ST_DONE;
                    end else begin
                        w_data_nxt = w_step;
                        w_rem_nxt  = r_rem - LEN_W'(1);
                    end
                end
            end
            ST_DONE: w_state_nxt = ST_IDLE;
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    assign bus.data  = r_data;
    assign bus.valid = r_valid;
    assign bus.busy  = (r_state != ST_IDLE);
    assign bus.done  = (r_state == ST_DONE);

endmodule

// File: tb/tb_pattern_gen.sv
// tb_pattern_gen
// Table of bursts driven through the generator; expected words are queued
// from a reference model when each burst is requested and popped as the
// stream transfers them. Hand-written sequences cover reset behaviour.
module tb_pattern_gen;

    logic clk;
    logic rst_n;

    pattern_gen_if #(.WIDTH(8), .LEN_W(8)) bus ();

    pattern_gen #(.WIDTH(8), .LEN_W(8)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.master)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [1:0] mode;
        logic [7:0] seed;
        logic [7:0] len;
        int         stall_at;
        int         stall_n;
        bit         mid_start;
        logic [7:0] exp_last;
        int         exp_beats;
    } vec_t;

    vec_t       vecs[10];
    logic [7:0] exp_q[$];
    int         n_checks = 0;
    int         n_fail   = 0;
    int         cyc      = 0;
    int         xfer_cnt = 0;
    int         done_cnt = 0;
    int         done_cyc = 0;
    int         last_xfer_cyc = 0;
    logic [7:0] last_word = '0;
    logic [7:0] held = '0;
    bit         prev_stall = 1'b0;
    bit         prev_done  = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [7:0] model_next(input logic [1:0] m, input logic [7:0] d);
        case (m)
            2'd0:    return d;
            2'd1:    return d ^ 8'hFF;
            2'd2:    return d + 8'd1;
            default: return (d << 1) | (d >> 7);
        endcase
    endfunction

    always @(posedge clk) cyc++;

    // stream / status monitor, sampled mid-cycle
    always @(negedge clk) begin
        if (!rst_n) begin
            prev_stall = 1'b0;
            prev_done  = 1'b0;
        end else begin
            if (prev_stall) begin
                check("stall_valid_held", bus.valid, 1);
                check("stall_data_held", bus.data, held);
            end
            if (prev_done) check("busy_after_done", bus.busy, 0);
            prev_stall = bus.valid && !bus.ready;
            held       = bus.data;
            if (bus.valid && bus.ready) begin
                if (exp_q.size() == 0) check("extra_word", 1, 0);
                else check("word", bus.data, exp_q.pop_front());
                xfer_cnt++;
                last_word     = bus.data;
                last_xfer_cyc = cyc;
            end
            if (bus.done) begin
                done_cnt++;
                done_cyc = cyc;
                check("done_valid_exclusive", bus.valid, 0);
                check("done_busy", bus.busy, 1);
            end
            prev_done = bus.done;
        end
    end

    task automatic run_burst(input vec_t v);
        int         k;
        int         xfer0;
        int         done0;
        int         start_cyc;
        int         stalled;
        logic [7:0] d;
        k = 0;
        while (bus.busy && k < 50) begin
            @(posedge clk); #1; k++;
        end
        if (bus.busy) check("idle_timeout", 1, 0);
        d = v.seed;
        for (int i = 0; i < int'(v.len); i++) begin
            exp_q.push_back(d);
            d = model_next(v.mode, d);
        end
        xfer0 = xfer_cnt;
        done0 = done_cnt;
        bus.start     = 1'b1;
        bus.mode      = v.mode;
        bus.seed      = v.seed;
        bus.burst_len = v.len;
        bus.ready     = 1'b1;
        @(posedge clk); #1;
        start_cyc = cyc;
        // scramble request inputs: the running burst must not see them
        bus.start     = 1'b0;
        bus.mode      = v.mode + 2'd1;
        bus.seed      = ~v.seed;
        bus.burst_len = v.len + 8'd3;
        stalled = 0;
        k = 0;
        while (done_cnt == done0 && k < 300) begin
            if (v.stall_at >= 0 && xfer_cnt - xfer0 == v.stall_at && stalled < v.stall_n) begin
                bus.ready = 1'b0;
                stalled++;
            end else begin
                bus.ready = 1'b1;
            end
            bus.start = (v.mid_start && k == 3);
            @(posedge clk); #1; k++;
        end
        bus.start = 1'b0;
        bus.ready = 1'b1;
        if (done_cnt == done0) check("done_timeout", 1, 0);
        @(posedge clk); #1;
        check("done_pulse_count", done_cnt - done0, 1);
        check("beats", xfer_cnt - xfer0, v.exp_beats);
        check("queue_drained", exp_q.size(), 0);
        exp_q.delete();
        if (v.len == 8'd0) begin
            check("len0_done_timing", done_cyc, start_cyc);
        end else begin
            check("done_after_last", done_cyc, last_xfer_cyc + 1);
            check("last_word", last_word, v.exp_last);
        end
    endtask

    initial begin
        int   k;
        int   xfer0;
        int   done0;
        vec_t rv;

        vecs[0] = '{2'd0, 8'hFF, 8'd1, -1, 0, 1'b0, 8'hFF, 1};
        vecs[1] = '{2'd0, 8'hFF, 8'd3, -1, 0, 1'b0, 8'hFF, 3};
        vecs[2] = '{2'd2, 8'hFE, 8'd4, -1, 0, 1'b0, 8'h01, 4};
        vecs[3] = '{2'd1, 8'hA5, 8'd4,  1, 2, 1'b0, 8'h5A, 4};
        vecs[4] = '{2'd3, 8'h01, 8'd9, -1, 0, 1'b1, 8'h01, 9};
        vecs[5] = '{2'd0, 8'h3C, 8'd0, -1, 0, 1'b0, 8'h00, 0};
        vecs[6] = '{2'd3, 8'h00, 8'd3, -1, 0, 1'b0, 8'h00, 3};
        vecs[7] = '{2'd3, 8'h80, 8'd2, -1, 0, 1'b0, 8'h01, 2};
        vecs[8] = '{2'd2, 8'hFF, 8'd2,  0, 3, 1'b0, 8'h00, 2};
        vecs[9] = '{2'd1, 8'h0F, 8'd3,  2, 1, 1'b1, 8'h0F, 3};

        rst_n         = 1'b0;
        bus.start     = 1'b0;
        bus.mode      = 2'd0;
        bus.seed      = 8'h00;
        bus.burst_len = 8'd0;
        bus.ready     = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_data", bus.data, 8'h00);
        check("rst_valid", bus.valid, 0);
        check("rst_busy", bus.busy, 0);
        check("rst_done", bus.done, 0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        for (int i = 0; i < 10; i++) run_burst(vecs[i]);

        // reset mid-burst: COUNT from 10, abort after two transfers
        for (int i = 0; i < 5; i++) exp_q.push_back(8'h10 + 8'(i));
        xfer0 = xfer_cnt;
        done0 = done_cnt;
        bus.start = 1'b1; bus.mode = 2'd2; bus.seed = 8'h10; bus.burst_len = 8'd5; bus.ready = 1'b1;
        @(posedge clk); #1;
        bus.start = 1'b0;
        k = 0;
        while (xfer_cnt - xfer0 < 2 && k < 20) begin
            @(posedge clk); #1; k++;
        end
        check("pre_reset_xfers", xfer_cnt - xfer0, 2);
        check("pre_reset_valid", bus.valid, 1);
        #2 rst_n = 1'b0;
        #1;
        check("async_rst_valid", bus.valid, 0);
        check("async_rst_data", bus.data, 8'h00);
        check("async_rst_busy", bus.busy, 0);
        check("async_rst_done", bus.done, 0);
        exp_q.delete();
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("no_done_after_abort", done_cnt - done0, 0);
        check("idle_after_abort", bus.busy, 0);
        rv = '{2'd2, 8'h10, 8'd2, -1, 0, 1'b0, 8'h11, 2};
        run_burst(rv);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1, "timeout");
    end

endmodule
